usb_fs_rx: RTL and testbench

USB_FS_RX -- requirements
Module: usb_fs_rx

---
 rtl/usb_fs_pkg.sv | 31 +++
 rtl/usb_fs_dpll.sv | 57 +++++
 rtl/usb_fs_rx.sv | 213 +++++++++++++++++++++
 tb/tb_usb_fs_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_pkg.sv
// Shared types and constants for the full-speed USB receive path.
// Line states are encoded as {D+, D-} so the decode is a direct cast.
package usb_fs_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_WAIT_IDLE
    } rx_state_t;

    localparam int         BIT_PHASES     = 4;
    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd5;
    localparam logic [2:0] STUFF_LEN      = 3'd6;

    function automatic line_state_t decode_ls(input logic dp, input logic dn);
        return line_state_t'({dp, dn});
    endfunction

    function automatic logic is_jk(input line_state_t s);
        return (s == LS_J) || (s == LS_K);
    endfunction

endpackage

// File: rtl/usb_fs_dpll.sv
// Input synchronizer, line-state decode and 4x oversampling bit-clock recovery.
// The phase counter re-centres on every J<->K edge; the strobe lands mid-bit.
module usb_fs_dpll
    import usb_fs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk48,
    input  logic       reset_n,
    input  logic       usb_d_p,
    input  logic       usb_d_n,
    output logic [1:0] line_state,
    output logic       bit_strobe
);

    localparam int PH_W = $clog2(BIT_PHASES);

    logic [SYNC_STAGES-1:0] dp_p0;
    logic [SYNC_STAGES-1:0] dn_p0;
    line_state_t            ls_p1;
    line_state_t            prev_ls;
    logic [PH_W-1:0]        phase;
    logic                   jk_change;

    // stage p0: synchronizer chain, idles at J
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            dp_p0 <= '1;
            dn_p0 <= '0;
        end else begin
            dp_p0[0] <= usb_d_p;
            dn_p0[0] <= usb_d_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dp_p0[i] <= dp_p0[i-1];
                dn_p0[i] <= dn_p0[i-1];
            end
        end
    end

    // stage p1: decoded line state drives edge detect and phase tracking
    assign ls_p1     = decode_ls(dp_p0[SYNC_STAGES-1], dn_p0[SYNC_STAGES-1]);
    assign jk_change = is_jk(ls_p1) && is_jk(prev_ls) && (ls_p1 != prev_ls);

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            prev_ls <= LS_J;
            phase   <= '0;
        end else begin
            prev_ls <= ls_p1;
            phase   <= jk_change ? '0 : phase + 1'b1;
        end
    end

    assign line_state = ls_p1;
    assign bit_strobe = (phase == PH_W'(1));

endmodule

// File: rtl/usb_fs_rx.sv
// Full-speed USB receiver: NRZI decode, bit unstuffing, packet framing FSM,
// byte assembly and bus-reset detection on top of the recovered bit strobe.
module usb_fs_rx
    import usb_fs_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_CYCLES = 120
) (
    input  logic       clk48,
    input  logic       reset_n,
    input  logic       usb_d_p,
    input  logic       usb_d_n,
    input  logic       tx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_pkt_start,
    output logic       rx_pkt_end,
    output logic       rx_err,
    output logic       rx_active,
    output logic       bus_reset
);

    localparam int             RC_W   = $clog2(RESET_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(RESET_CYCLES);

    logic [1:0]      ls_raw;
    line_state_t     ls;
    logic            bit_strobe;
    logic            nrzi_bit;

    rx_state_t       state, state_nxt;
    line_state_t     last_ls, last_ls_nxt;
    logic [2:0]      zero_cnt, zero_nxt;
    logic [2:0]      ones_cnt, ones_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [1:0]      se0_cnt, se0_nxt;
    logic            j_cnt, j_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic [7:0]      rx_data_nxt;
    logic            valid_nxt, start_nxt, end_nxt, err_nxt;
    logic [RC_W-1:0] se0_run;

    usb_fs_dpll #(.SYNC_STAGES(SYNC_STAGES)) u_dpll (
        .clk48      (clk48),
        .reset_n    (reset_n),
        .usb_d_p    (usb_d_p),
        .usb_d_n    (usb_d_n),
        .line_state (ls_raw),
        .bit_strobe (bit_strobe)
    );

    assign ls       = line_state_t'(ls_raw);
    assign nrzi_bit = (ls == last_ls);

    always_comb begin
        state_nxt   = state;
        last_ls_nxt = last_ls;
        zero_nxt    = zero_cnt;
        ones_nxt    = ones_cnt;
        bit_nxt     = bit_cnt;
        se0_nxt     = se0_cnt;
        j_nxt       = j_cnt;
        shreg_nxt   = shreg;
        rx_data_nxt = rx_data;
        valid_nxt   = 1'b0;
        start_nxt   = 1'b0;
        end_nxt     = 1'b0;
        err_nxt     = 1'b0;

        if (bit_strobe) begin
            last_ls_nxt = ls;
        end

        if (tx_en) begin
            state_nxt = ST_IDLE;
        end else if (bit_strobe) begin
            case (state)
                ST_IDLE: begin
                    if (ls == LS_K) begin
                        state_nxt = ST_SYNC;
                        zero_nxt  = 3'd1;
                    end
                end
                ST_SYNC: begin
                    if (!is_jk(ls)) begin
                        state_nxt = ST_IDLE;
                    end else if (!nrzi_bit) begin
                        zero_nxt = (zero_cnt == 3'd7) ? zero_cnt : zero_cnt + 3'd1;
                    end else if (zero_cnt >= SYNC_MIN_ZEROS) begin
                        state_nxt = ST_DATA;
                        start_nxt = 1'b1;
                        ones_nxt  = '0;
                        bit_nxt   = '0;
                        se0_nxt   = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (ls == LS_SE1) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_WAIT_IDLE;
                        j_nxt     = 1'b0;
                    end else if (ls == LS_SE0) begin
                        if (se0_cnt == 2'd3) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_WAIT_IDLE;
                            j_nxt     = 1'b0;
                        end else begin
                            se0_nxt = se0_cnt + 2'd1;
                        end
                    end else if (se0_cnt != 2'd0) begin
                        // J after SE0 closes the packet; K after SE0 is a malformed EOP
                        if (ls == LS_J) begin
                            end_nxt   = 1'b1;
                            err_nxt   = (bit_cnt != 3'd0);
                            state_nxt = ST_IDLE;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_WAIT_IDLE;
                            j_nxt     = 1'b0;
                        end
                    end else if (ones_cnt == STUFF_LEN) begin
                        if (nrzi_bit) begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_WAIT_IDLE;
                            j_nxt     = 1'b0;
                        end else begin
                            ones_nxt = '0;
                        end
                    end else begin
                        shreg_nxt = {nrzi_bit, shreg[7:1]};
                        ones_nxt  = nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                        bit_nxt   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            valid_nxt   = 1'b1;
                            rx_data_nxt = {nrzi_bit, shreg[7:1]};
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (ls == LS_J) begin
                        if (j_cnt) begin
                            state_nxt = ST_IDLE;
                            j_nxt     = 1'b0;
                        end else begin
                            j_nxt = 1'b1;
                        end
                    end else begin
                        j_nxt = 1'b0;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // stage p2: registered FSM state, counters and output strobes
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            last_ls      <= LS_J;
            zero_cnt     <= '0;
            ones_cnt     <= '0;
            bit_cnt      <= '0;
            se0_cnt      <= '0;
            j_cnt        <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_pkt_start <= 1'b0;
            rx_pkt_end   <= 1'b0;
            rx_err       <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_ls      <= last_ls_nxt;
            zero_cnt     <= zero_nxt;
            ones_cnt     <= ones_nxt;
            bit_cnt      <= bit_nxt;
            se0_cnt      <= se0_nxt;
            j_cnt        <= j_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= valid_nxt;
            rx_pkt_start <= start_nxt;
            rx_pkt_end   <= end_nxt;
            rx_err       <= err_nxt;
        end
    end

    always_ff @(posedge clk48) begin
        shreg <= shreg_nxt;
    end

    assign rx_active = (state == ST_DATA) && !tx_en;

    // bus reset: saturating count of consecutive synchronized SE0 clocks
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            se0_run   <= '0;
            bus_reset <= 1'b0;
        end else if (ls != LS_SE0) begin
            se0_run   <= '0;
            bus_reset <= 1'b0;
        end else begin
            if (se0_run != RC_MAX) begin
                se0_run <= se0_run + 1'b1;
            end
            if (se0_run >= RC_MAX - 1'b1) begin
                bus_reset <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_fs_rx.sv
// Directed bench for usb_fs_rx: a bit-level NRZI/stuffing line driver plus an
// event monitor; each scenario task checks its own expected counts and bytes.
`timescale 1ns/1ps
module tb_usb_fs_rx;

    logic       clk48 = 1'b0;
    logic       reset_n;
    logic       usb_d_p = 1'b1;
    logic       usb_d_n = 1'b0;
    logic       tx_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_pkt_start, rx_pkt_end, rx_err, rx_active, bus_reset;

    int checks = 0;
    int errors = 0;

    int n_start = 0, n_valid = 0, n_end = 0, n_err = 0, n_end_err = 0;
    int n_act_bad = 0, n_active = 0;
    logic [7:0] got[$];

    real  bit_ns = 80.0;
    logic cur_k = 1'b0;
    int   ones = 0;

    always #10 clk48 = ~clk48;

    usb_fs_rx #(.SYNC_STAGES(2), .RESET_CYCLES(120)) dut (
        .clk48        (clk48),
        .reset_n      (reset_n),
        .usb_d_p      (usb_d_p),
        .usb_d_n      (usb_d_n),
        .tx_en        (tx_en),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_pkt_start (rx_pkt_start),
        .rx_pkt_end   (rx_pkt_end),
        .rx_err       (rx_err),
        .rx_active    (rx_active),
        .bus_reset    (bus_reset)
    );

    always @(negedge clk48) begin
        if (rx_valid) got.push_back(rx_data);
        if (rx_pkt_start) n_start++;
        if (rx_valid) n_valid++;
        if (rx_pkt_end) n_end++;
        if (rx_err) n_err++;
        if (rx_pkt_end && rx_err) n_end_err++;
        if ((rx_pkt_end || rx_err) && rx_active) n_act_bad++;
        if (rx_active) n_active++;
    end

    task automatic line(input logic dp, input logic dn);
        usb_d_p = dp;
        usb_d_n = dn;
        #(bit_ns);
    endtask

    task automatic raw_bit(input logic b);
        if (!b) cur_k = !cur_k;
        line(!cur_k, cur_k);
    endtask

    task automatic idle(input int n);
        cur_k = 1'b0;
        repeat (n) line(1'b1, 1'b0);
    endtask

    task automatic send_sync();
        cur_k = 1'b0;
        for (int i = 0; i < 7; i++) raw_bit(1'b0);
        raw_bit(1'b1);
        ones = 0;
    endtask

    task automatic data_bit(input logic b);
        raw_bit(b);
        if (b) begin
            ones++;
            if (ones == 6) begin
                raw_bit(1'b0);
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) data_bit(v[i]);
    endtask

    task automatic send_eop();
        line(1'b0, 1'b0);
        line(1'b0, 1'b0);
        idle(5);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #23;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %0h expected 0", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_pkt_start !== 1'b0) begin errors++; $display("FAIL reset_pkt_start: got %b expected 0", rx_pkt_start); end
        checks++; if (rx_pkt_end !== 1'b0) begin errors++; $display("FAIL reset_pkt_end: got %b expected 0", rx_pkt_end); end
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL reset_rx_err: got %b expected 0", rx_err); end
        checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL reset_rx_active: got %b expected 0", rx_active); end
        checks++; if (bus_reset !== 1'b0) begin errors++; $display("FAIL reset_bus_reset: got %b expected 0", bus_reset); end
        repeat (3) @(negedge clk48);
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_single_byte();
        int bs = n_start, bv = n_valid, be = n_end, br = n_err, ba = n_act_bad, bq = got.size();
        @(negedge clk48);
        send_sync();
        send_byte(8'hA5);
        send_eop();
        checks++; if (n_start - bs !== 1) begin errors++; $display("FAIL single_start: got %0d expected 1", n_start - bs); end
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL single_valid: got %0d expected 1", n_valid - bv); end
        checks++; if (got.size() > bq && got[bq] !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", got[bq]); end
        checks++; if (n_end - be !== 1) begin errors++; $display("FAIL single_end: got %0d expected 1", n_end - be); end
        checks++; if (n_err - br !== 0) begin errors++; $display("FAIL single_err: got %0d expected 0", n_err - br); end
        checks++; if (n_act_bad - ba !== 0) begin errors++; $display("FAIL single_active_fall: got %0d expected 0", n_act_bad - ba); end
    endtask

    task automatic test_stuffed();
        int bv = n_valid, be = n_end, br = n_err, bq = got.size();
        @(negedge clk48);
        send_sync();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_eop();
        checks++; if (n_valid - bv !== 2) begin errors++; $display("FAIL stuffed_valid: got %0d expected 2", n_valid - bv); end
        checks++; if (got.size() > bq && got[bq] !== 8'hFF) begin errors++; $display("FAIL stuffed_byte0: got %0h expected ff", got[bq]); end
        checks++; if (got.size() > bq + 1 && got[bq+1] !== 8'hFF) begin errors++; $display("FAIL stuffed_byte1: got %0h expected ff", got[bq+1]); end
        checks++; if (n_err - br !== 0) begin errors++; $display("FAIL stuffed_err: got %0d expected 0", n_err - br); end
        checks++; if (n_end - be !== 1) begin errors++; $display("FAIL stuffed_end: got %0d expected 1", n_end - be); end
    endtask

    task automatic test_stuff_error();
        int bv = n_valid, be = n_end, br = n_err, ba = n_act_bad, bq;
        @(negedge clk48);
        send_sync();
        for (int i = 0; i < 7; i++) raw_bit(1'b1);
        send_eop();
        checks++; if (n_err - br !== 1) begin errors++; $display("FAIL stufferr_err: got %0d expected 1", n_err - br); end
        checks++; if (n_end - be !== 0) begin errors++; $display("FAIL stufferr_end: got %0d expected 0", n_end - be); end
        checks++; if (n_valid - bv !== 0) begin errors++; $display("FAIL stufferr_valid: got %0d expected 0", n_valid - bv); end
        checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL stufferr_active: got %b expected 0", rx_active); end
        checks++; if (n_act_bad - ba !== 0) begin errors++; $display("FAIL stufferr_active_fall: got %0d expected 0", n_act_bad - ba); end
        bv = n_valid; be = n_end; bq = got.size();
        @(negedge clk48);
        send_sync();
        send_byte(8'h5A);
        send_eop();
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL recover_valid: got %0d expected 1", n_valid - bv); end
        checks++; if (got.size() > bq && got[bq] !== 8'h5A) begin errors++; $display("FAIL recover_data: got %0h expected 5a", got[bq]); end
        checks++; if (n_end - be !== 1) begin errors++; $display("FAIL recover_end: got %0d expected 1", n_end - be); end
    endtask

    task automatic test_residual();
        int bv = n_valid, be = n_end, br = n_err, bx = n_end_err, bq = got.size();
        @(negedge clk48);
        send_sync();
        send_byte(8'h3C);
        data_bit(1'b1); data_bit(1'b0); data_bit(1'b1); data_bit(1'b1);
        send_eop();
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL resid_valid: got %0d expected 1", n_valid - bv); end
        checks++; if (got.size() > bq && got[bq] !== 8'h3C) begin errors++; $display("FAIL resid_data: got %0h expected 3c", got[bq]); end
        checks++; if (n_end - be !== 1) begin errors++; $display("FAIL resid_end: got %0d expected 1", n_end - be); end
        checks++; if (n_err - br !== 1) begin errors++; $display("FAIL resid_err: got %0d expected 1", n_err - br); end
        checks++; if (n_end_err - bx !== 1) begin errors++; $display("FAIL resid_same_cycle: got %0d expected 1", n_end_err - bx); end
    endtask

    task automatic test_bus_reset();
        @(negedge clk48);
        usb_d_p = 1'b0;
        usb_d_n = 1'b0;
        repeat (121) @(posedge clk48);
        #1;
        checks++; if (bus_reset !== 1'b0) begin errors++; $display("FAIL busreset_early: got %b expected 0", bus_reset); end
        @(posedge clk48);
        #1;
        checks++; if (bus_reset !== 1'b1) begin errors++; $display("FAIL busreset_rise: got %b expected 1", bus_reset); end
        repeat (8) @(posedge clk48);
        #1;
        checks++; if (bus_reset !== 1'b1) begin errors++; $display("FAIL busreset_hold: got %b expected 1", bus_reset); end
        @(negedge clk48);
        usb_d_p = 1'b1;
        usb_d_n = 1'b0;
        repeat (2) @(posedge clk48);
        #1;
        checks++; if (bus_reset !== 1'b1) begin errors++; $display("FAIL busreset_latency: got %b expected 1", bus_reset); end
        @(posedge clk48);
        #1;
        checks++; if (bus_reset !== 1'b0) begin errors++; $display("FAIL busreset_fall: got %b expected 0", bus_reset); end
        idle(4);
    endtask

    task automatic test_long_packet(input real bn);
        int bv = n_valid, be = n_end, br = n_err, bq = got.size(), bad = 0;
        logic [7:0] v;
        bit_ns = bn;
        @(negedge clk48);
        send_sync();
        for (int i = 0; i < 64; i++) begin
            v = 8'(i * 29 + 7);
            if (i == 10 || i == 11) v = 8'hFF;
            send_byte(v);
        end
        send_eop();
        for (int i = 0; i < 64; i++) begin
            v = 8'(i * 29 + 7);
            if (i == 10 || i == 11) v = 8'hFF;
            if (got.size() <= bq + i || got[bq+i] !== v) bad++;
        end
        checks++; if (n_valid - bv !== 64) begin errors++; $display("FAIL long_valid: got %0d expected 64", n_valid - bv); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL long_data: got %0d bad bytes expected 0", bad); end
        checks++; if (n_err - br !== 0) begin errors++; $display("FAIL long_err: got %0d expected 0", n_err - br); end
        checks++; if (n_end - be !== 1) begin errors++; $display("FAIL long_end: got %0d expected 1", n_end - be); end
        bit_ns = 80.0;
    endtask

    task automatic test_tx_en();
        int bs = n_start, bv = n_valid, be = n_end, br = n_err, bn = n_active;
        tx_en = 1'b1;
        @(negedge clk48);
        send_sync();
        send_byte(8'hA5);
        send_eop();
        checks++; if (n_start - bs !== 0) begin errors++; $display("FAIL txen_start: got %0d expected 0", n_start - bs); end
        checks++; if (n_valid - bv !== 0) begin errors++; $display("FAIL txen_valid: got %0d expected 0", n_valid - bv); end
        checks++; if (n_end - be !== 0) begin errors++; $display("FAIL txen_end: got %0d expected 0", n_end - be); end
        checks++; if (n_err - br !== 0) begin errors++; $display("FAIL txen_err: got %0d expected 0", n_err - br); end
        checks++; if (n_active - bn !== 0) begin errors++; $display("FAIL txen_active: got %0d cycles expected 0", n_active - bn); end
        tx_en = 1'b0;
        idle(4);
    endtask

    task automatic test_reset_mid_packet();
        int be = n_end, br = n_err, bv, bq;
        @(negedge clk48);
        send_sync();
        data_bit(1'b1); data_bit(1'b0); data_bit(1'b0); data_bit(1'b1);
        checks++; if (rx_active !== 1'b1) begin errors++; $display("FAIL midreset_active_before: got %b expected 1", rx_active); end
        @(negedge clk48);
        reset_n = 1'b0;
        usb_d_p = 1'b1;
        usb_d_n = 1'b0;
        #1;
        checks++; if (rx_active !== 1'b0) begin errors++; $display("FAIL midreset_active: got %b expected 0", rx_active); end
        repeat (3) @(negedge clk48);
        reset_n = 1'b1;
        idle(6);
        checks++; if (n_end - be !== 0) begin errors++; $display("FAIL midreset_end: got %0d expected 0", n_end - be); end
        checks++; if (n_err - br !== 0) begin errors++; $display("FAIL midreset_err: got %0d expected 0", n_err - br); end
        bv = n_valid; bq = got.size();
        @(negedge clk48);
        send_sync();
        send_byte(8'hC3);
        send_eop();
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL midreset_next_valid: got %0d expected 1", n_valid - bv); end
        checks++; if (got.size() > bq && got[bq] !== 8'hC3) begin errors++; $display("FAIL midreset_next_data: got %0h expected c3", got[bq]); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_stuffed();
        test_stuff_error();
        test_residual();
        test_bus_reset();
        test_long_packet(80.8);
        test_long_packet(79.2);
        test_tx_en();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
